mac32_stim_gen: RTL and testbench

Synthesizable stimulus generator for the 32-bit floating-point MAC, which computes A + B·C. It sends operand triples to the MAC over a valid/ready handshake and waits for the MAC result. For each completed transaction it presents A, B, C and the result stable for one reporting cycle, so a checker or scoreboard can compare them. When the programmed test count is done, or the MAC stops responding, it raises a done indication that plays the role of the bench's end-of-simulation event.

---
 rtl/mac32_stim_gen.sv | 164 ++++++++++++++++
 tb/tb_mac32_stim_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac32_stim_gen.sv
// mac32_stim_gen: operand stimulus generator for a 32-bit floating-point MAC (A + B*C).
// Draws pseudo-random normal-range operands from a Galois LFSR and sends them over a
// valid/ready handshake. Each returned result is reported alongside its operands for
// one cycle. The run ends when the programmed test count is done or the MAC stops answering.
module mac32_stim_gen #(
    parameter int          PARM_XLEN = 32,
    parameter int          PARM_EXP  = 8,
    parameter int          PARM_MANT = 23,
    parameter int          PARM_BIAS = 127,
    parameter int          NUM_TESTS = 16,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    localparam int         CNT_W     = (NUM_TESTS < 1) ? 1 : $clog2(NUM_TESTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic [PARM_XLEN-1:0] A_o,
    output logic [PARM_XLEN-1:0] B_o,
    output logic [PARM_XLEN-1:0] C_o,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    input  logic                 res_valid_i,
    input  logic [PARM_XLEN-1:0] Result_i,
    output logic [PARM_XLEN-1:0] Result_o,
    output logic                 result_ready_o,
    output logic [CNT_W-1:0]     test_cnt_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o
);

    localparam int          TO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [TO_W-1:0]  WAIT_LAST = (TIMEOUT < 1) ? '0 : TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_TESTS);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        ISSUE,
        WAIT,
        REPORT,
        DONE
    } state_t;

    state_t          state;
    logic [31:0]     lfsr;
    logic [1:0]      gen_idx;
    logic [TO_W-1:0] wait_cnt;
    logic [31:0]     lfsr_step;

    // Galois right-shift LFSR step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Map an LFSR word to a normal float: exponent confined to BIAS-8 .. BIAS+7 so the
    // operand is never zero, subnormal, Inf or NaN.
    function automatic logic [PARM_XLEN-1:0] fmt_operand(input logic [31:0] l);
        logic [PARM_EXP-1:0] e;
        e = PARM_EXP'(PARM_BIAS - 8) + PARM_EXP'(l[26:23]);
        return PARM_XLEN'({l[31], e, PARM_MANT'(l[22:0])});
    endfunction

    assign lfsr_step = lfsr_next(lfsr);

    // Control FSM with registered outputs; one LFSR step per GEN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lfsr           <= LFSR_INIT;
            gen_idx        <= 2'd0;
            wait_cnt       <= '0;
            A_o            <= '0;
            B_o            <= '0;
            C_o            <= '0;
            op_valid_o     <= 1'b0;
            Result_o       <= '0;
            result_ready_o <= 1'b0;
            test_cnt_o     <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            result_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (NUM_TESTS == 0) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy_o  <= 1'b1;
                            gen_idx <= 2'd0;
                            state   <= GEN;
                        end
                    end
                end
                GEN: begin
                    lfsr    <= lfsr_step;
                    gen_idx <= gen_idx + 2'd1;
                    case (gen_idx)
                        2'd0:    A_o <= fmt_operand(lfsr_step);
                        2'd1:    B_o <= fmt_operand(lfsr_step);
                        default: begin
                            C_o        <= fmt_operand(lfsr_step);
                            op_valid_o <= 1'b1;
                            state      <= ISSUE;
                        end
                    endcase
                end
                ISSUE: begin
                    if (op_valid_o && op_ready_i) begin
                        op_valid_o <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (res_valid_i) begin
                        Result_o       <= Result_i;
                        result_ready_o <= 1'b1;
                        test_cnt_o     <= test_cnt_o + 1'b1;
                        state          <= REPORT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (test_cnt_o == CNT_LAST) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else begin
                        gen_idx <= 2'd0;
                        state   <= GEN;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        timeout_o  <= 1'b0;
                        test_cnt_o <= '0;
                        if (NUM_TESTS != 0) begin
                            done_o  <= 1'b0;
                            busy_o  <= 1'b1;
                            gen_idx <= 2'd0;
                            state   <= GEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac32_stim_gen.sv
// Scoreboard bench for mac32_stim_gen: a responder plays the MAC, pushes the expected
// report for every handshake, and a monitor pops and compares on each result_ready_o.
module tb_mac32_stim_gen;

    localparam int NT = 4;
    localparam int TO = 64;
    localparam int CW = $clog2(NT + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [31:0]   A_o, B_o, C_o, Result_o;
    logic          op_valid_o, result_ready_o, busy_o, done_o, timeout_o;
    logic          op_ready_i = 1'b1;
    logic          res_valid_i = 1'b0;
    logic [31:0]   Result_i = 32'h0;
    logic [CW-1:0] test_cnt_o;

    mac32_stim_gen #(
        .PARM_XLEN(32), .PARM_EXP(8), .PARM_MANT(23), .PARM_BIAS(127),
        .NUM_TESTS(NT), .TIMEOUT(TO), .SEED(32'h0000_0001)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .A_o(A_o), .B_o(B_o), .C_o(C_o),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .res_valid_i(res_valid_i), .Result_i(Result_i),
        .Result_o(Result_o), .result_ready_o(result_ready_o),
        .test_cnt_o(test_cnt_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", nm);
    endtask

    // Reference LFSR and operand format, written independently of the design.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    function automatic logic [31:0] m_fmt(input logic [31:0] l);
        logic [7:0] e;
        e = 8'd119 + {4'd0, l[26:23]};
        return {l[31], e, l[22:0]};
    endfunction

    // Stand-in MAC: any deterministic function of the operands suffices for loopback.
    function automatic logic [31:0] resp_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return (a ^ {b[15:0], b[31:16]}) + c;
    endfunction

    function automatic logic exp_ok(input logic [31:0] v);
        return (v[30:23] >= 8'd119) && (v[30:23] <= 8'd134);
    endfunction

    typedef struct {
        logic [31:0] a, b, c, r;
        int          idx;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_lfsr = 32'h1;
    int mode = 0;          // 0 normal, 1 never respond, 2 respond only at handshake
    int lat = 1;
    int run_hs = 0;
    int hs_edge = 0;
    int pulses = 0;
    int last_rr_edge = 0;

    // Responder: detects the coming handshake edge, predicts the operands, answers.
    initial begin : responder
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && op_valid_o && op_ready_i) begin
                hs_edge = cyc + 1;
                run_hs++;
                m_lfsr = m_step(m_lfsr); e.a = m_fmt(m_lfsr);
                m_lfsr = m_step(m_lfsr); e.b = m_fmt(m_lfsr);
                m_lfsr = m_step(m_lfsr); e.c = m_fmt(m_lfsr);
                e.r = resp_fn(e.a, e.b, e.c);
                e.idx = run_hs;
                if (mode == 2) begin
                    res_valid_i = 1'b1;
                    Result_i = 32'hDEAD_BEEF;
                end
                @(posedge clk); #1;
                res_valid_i = 1'b0;
                if (mode == 0) begin
                    exp_q.push_back(e);
                    repeat (lat - 1) begin @(posedge clk); #1; end
                    res_valid_i = 1'b1;
                    Result_i = resp_fn(A_o, B_o, C_o);
                    @(posedge clk); #1;
                    res_valid_i = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every report strobe against the scoreboard head.
    initial begin : monitor
        exp_t e;
        logic prev_rr;
        prev_rr = 1'b0;
        forever begin
            @(negedge clk);
            if (result_ready_o) begin
                pulses++;
                last_rr_edge = cyc;
                chk("rr_single_cycle", 32'(prev_rr), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_report actual=%h required=none", Result_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rpt_a", A_o, e.a);
                    chk("rpt_b", B_o, e.b);
                    chk("rpt_c", C_o, e.c);
                    chk("rpt_result", Result_o, e.r);
                    chk("rpt_cnt", 32'(test_cnt_o), 32'(e.idx));
                    chk("rpt_exp_range", 32'({exp_ok(A_o), exp_ok(B_o), exp_ok(C_o)}), 32'h7);
                end
            end
            prev_rr = result_ready_o;
        end
    end

    int k;

    task automatic do_start(output int edge_k);
        pulses = 0;
        run_hs = 0;
        start_i = 1'b1;
        edge_k = cyc + 1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_opv(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_valid_o && n < 100) begin @(negedge clk); n++; end
        if (!op_valid_o) fail_now(nm);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_o && n < 400) begin @(negedge clk); n++; end
        if (!done_o) fail_now(nm);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_abc"}, A_o | B_o | C_o, 32'h0);
        chk({nm, "_result"}, Result_o, 32'h0);
        chk({nm, "_flags"}, 32'({op_valid_o, result_ready_o, busy_o, done_o, timeout_o}), 32'h0);
        chk({nm, "_cnt"}, 32'(test_cnt_o), 32'h0);
    endtask

    initial begin : main
        int n;
        logic [31:0] ha, hb, hc;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Run 1: ready tied high, result one cycle after handshake.
        mode = 0; lat = 1;
        do_start(k);
        wait_opv("run1_opv");
        chk("run1_opv_rise_edge", 32'(cyc), 32'(k + 3));
        chk("run1_busy", 32'(busy_o), 32'h1);
        chk("run1_first_a", A_o, 32'hBBA0_0003);
        chk("run1_first_b", B_o, 32'hBBB0_0002);
        chk("run1_first_c", C_o, 32'h3B98_0001);
        wait_done("run1_done");
        chk("run1_done_edge", 32'(cyc), 32'(last_rr_edge + 1));
        chk("run1_cnt", 32'(test_cnt_o), 32'(NT));
        chk("run1_pulses", 32'(pulses), 32'(NT));
        chk("run1_flags", 32'({busy_o, timeout_o}), 32'h0);

        // Run 2: latency 2, with start_i pulsed while busy.
        lat = 2;
        do_start(k);
        repeat (8) @(posedge clk);
        #1;
        start_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done("run2_done");
        chk("run2_cnt", 32'(test_cnt_o), 32'(NT));
        chk("run2_pulses", 32'(pulses), 32'(NT));

        // Run 3: op_ready_i held low for 10 cycles.
        lat = 1;
        op_ready_i = 1'b0;
        do_start(k);
        wait_opv("run3_opv");
        ha = A_o; hb = B_o; hc = C_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("run3_hold_valid", 32'(op_valid_o), 32'h1);
            chk("run3_hold_ops", A_o ^ ha ^ B_o ^ hb ^ (C_o - hc), 32'h0);
        end
        @(posedge clk); #1;
        op_ready_i = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        @(negedge clk);
        chk("run3_hs_edge", 32'(hs_edge), 32'(k));
        chk("run3_valid_drop", 32'(op_valid_o), 32'h0);
        wait_done("run3_done");
        chk("run3_cnt", 32'(test_cnt_o), 32'(NT));

        // Run 4: the MAC never answers.
        mode = 1;
        do_start(k);
        wait_done("run4_done");
        chk("run4_timeout_edge", 32'(cyc), 32'(hs_edge + TO));
        chk("run4_timeout", 32'(timeout_o), 32'h1);
        chk("run4_cnt", 32'(test_cnt_o), 32'h0);
        chk("run4_pulses", 32'(pulses), 32'h0);

        // Run 5: result only in the handshake cycle, which must be ignored.
        mode = 2;
        do_start(k);
        wait_done("run5_done");
        chk("run5_timeout", 32'(timeout_o), 32'h1);
        chk("run5_pulses", 32'(pulses), 32'h0);
        chk("run5_cnt", 32'(test_cnt_o), 32'h0);

        // Run 6: asynchronous reset during WAIT of transaction 2.
        mode = 0;
        do_start(k);
        n = 0;
        while (pulses < 1 && n < 100) begin @(negedge clk); n++; end
        if (pulses < 1) fail_now("run6_first_report");
        mode = 1;
        n = 0;
        while (run_hs < 2 && n < 100) begin @(negedge clk); n++; end
        if (run_hs < 2) fail_now("run6_second_hs");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        m_lfsr = 32'h1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mode = 0;
        @(posedge clk); #1;
        do_start(k);
        wait_opv("run6_opv");
        chk("run6_reseeded_a", A_o, 32'hBBA0_0003);
        wait_done("run6_done");
        chk("run6_cnt", 32'(test_cnt_o), 32'(NT));

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
